sprite_mover: RTL and testbench

Parametrised per-frame sprite motion controller for the maze playfield. It converts WASD keycodes into stepped movement with a facing direction. Wall contacts raised by the collision logic drive a timed bounce-back state machine. It also produces the pixel-hit flag and start/end zone flags used by the renderer and the level sequencer.

---
 rtl/sprite_pkg.sv | 31 +++
 rtl/sprite_mover_frame_tick.sv | 29 ++
 rtl/sprite_mover.sv | 200 ++++++++++++++++++++
 tb/tb_sprite_mover.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and helpers for the sprite motion blocks.
//   dir_t      : facing / move direction (L, R, U, D)
//   mv_state_t : motion FSM states (IDLE, MOVE, BOUNCE)
//   KEY_*      : WASD keycodes
//   opposite() : reverse direction used for bounce-back
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    BOUNCE = 2'd2
  } mv_state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  // Encoding pairs L/R and U/D on bit 0, so flipping it reverses direction.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/sprite_mover_frame_tick.sv
// frame_tick: samples the frame strobe on Clk and emits a registered
// one-cycle pulse for each rising edge of it.
//   Clk       in  system clock
//   Reset     in  synchronous, active-high reset
//   frame_clk in  frame strobe
//   o_tick    out one-cycle pulse, one Clk after frame_clk is seen high
module frame_tick (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic o_tick
);

  logic r_frame;
  logic r_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_frame <= frame_clk;
      r_tick  <= frame_clk & ~r_frame;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame sprite motion controller.
// WASD keys step the sprite once per frame tick; a wall contact while moving
// triggers a timed bounce-back. Also derives pixel-hit and zone flags.
// Optional feature: define SPRITE_BOOST_EN to double the step while boost=1
// (IDLE/MOVE only; bounce always uses STEP).
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   frame_clk           frame strobe (tick source)
//   restart             returns motion state to the start position
//   enable              sprite active; gates ticks and zone flags
//   keycode[7:0]        current key
//   blocked[3:0]        wall contact per side [0]=L [1]=R [2]=U [3]=D
//   boost               speed modifier (optional feature)
//   DrawX, DrawY        current pixel
//   xpos, ypos          sprite top-left
//   dx, dy              pixel offset from sprite origin (wrapping)
//   facing              0=L 1=R 2=U 3=D
//   moving, bouncing    FSM state flags
//   in_sprite           pixel inside sprite box
//   at_start, at_end    zone flags
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int POS_W         = 10,
  parameter int SPR_W         = 20,
  parameter int SPR_H         = 20,
  parameter int STEP          = 1,
  parameter int START_X       = 336,
  parameter int START_Y       = 33,
  parameter int X_MAX         = 620,
  parameter int Y_MAX         = 460,
  parameter int BOUNCE_FRAMES = 4,
  parameter int START_LINE    = 64,
  parameter int END_LINE      = 416
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             restart,
  input  logic             enable,
  input  logic [7:0]       keycode,
  input  logic [3:0]       blocked,
  input  logic             boost,
  input  logic [POS_W-1:0] DrawX,
  input  logic [POS_W-1:0] DrawY,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic [POS_W-1:0] dx,
  output logic [POS_W-1:0] dy,
  output logic [1:0]       facing,
  output logic             moving,
  output logic             bouncing,
  output logic             in_sprite,
  output logic             at_start,
  output logic             at_end
);

  localparam int CNT_W = (BOUNCE_FRAMES > 1) ? $clog2(BOUNCE_FRAMES) : 1;
  localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);

  logic             w_tick;
  mv_state_t        r_state, w_state_nxt;
  dir_t             r_face, w_face_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [POS_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic             w_key_vld;
  dir_t             w_key_dir;
  logic [POS_W-1:0] w_step_run;
  logic             w_mv;
  dir_t             w_mv_dir;
  logic [POS_W-1:0] w_mv_step;
  logic [POS_W:0]   w_x_inc, w_y_inc;

  frame_tick u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .o_tick    (w_tick)
  );

`ifdef SPRITE_BOOST_EN
  assign w_step_run = boost ? POS_W'(2 * STEP) : STEP_V;
`else
  logic w_unused_boost;
  assign w_unused_boost = boost;
  assign w_step_run     = STEP_V;
`endif

  // Key decode; codes are exclusive so the A > D > W > S order is the case order.
  always_comb begin
    w_key_vld = 1'b1;
    w_key_dir = DIR_L;
    case (keycode)
      KEY_A:   w_key_dir = DIR_L;
      KEY_D:   w_key_dir = DIR_R;
      KEY_W:   w_key_dir = DIR_U;
      KEY_S:   w_key_dir = DIR_D;
      default: w_key_vld = 1'b0;
    endcase
  end

  // State register (restart shares the reset path for motion state)
  always_ff @(posedge Clk) begin
    if (Reset || restart) begin
      r_state <= IDLE;
      r_face  <= DIR_D;
      r_cnt   <= '0;
      r_x     <= POS_W'(START_X);
      r_y     <= POS_W'(START_Y);
    end else begin
      r_state <= w_state_nxt;
      r_face  <= w_face_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Next-state: also selects the move (direction, step) for this tick.
  always_comb begin
    w_state_nxt = r_state;
    w_face_nxt  = r_face;
    w_cnt_nxt   = r_cnt;
    w_mv        = 1'b0;
    w_mv_dir    = r_face;
    w_mv_step   = w_step_run;
    if (w_tick && enable) begin
      case (r_state)
        IDLE: begin
          if (w_key_vld) begin
            w_face_nxt = w_key_dir;
            if (!blocked[w_key_dir]) begin
              w_mv        = 1'b1;
              w_mv_dir    = w_key_dir;
              w_state_nxt = MOVE;
            end
          end
        end
        MOVE: begin
          if (!w_key_vld) begin
            w_state_nxt = IDLE;
          end else if (blocked[r_face]) begin
            // facing is kept so the bounce direction stays fixed for its duration
            w_state_nxt = BOUNCE;
            w_cnt_nxt   = CNT_W'(BOUNCE_FRAMES - 1);
            w_mv        = 1'b1;
            w_mv_dir    = opposite(r_face);
            w_mv_step   = STEP_V;
          end else begin
            w_face_nxt = w_key_dir;
            w_mv       = 1'b1;
            w_mv_dir   = w_key_dir;
          end
        end
        BOUNCE: begin
          w_mv      = 1'b1;
          w_mv_dir  = opposite(r_face);
          w_mv_step = STEP_V;
          if (r_cnt == '0) w_state_nxt = IDLE;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Saturating position update; one extra bit catches overflow on +step.
  assign w_x_inc = {1'b0, r_x} + {1'b0, w_mv_step};
  assign w_y_inc = {1'b0, r_y} + {1'b0, w_mv_step};

  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (w_mv) begin
      case (w_mv_dir)
        DIR_L: w_x_nxt = (r_x < w_mv_step) ? '0 : r_x - w_mv_step;
        DIR_R: w_x_nxt = (w_x_inc > (POS_W+1)'(X_MAX)) ? POS_W'(X_MAX) : w_x_inc[POS_W-1:0];
        DIR_U: w_y_nxt = (r_y < w_mv_step) ? '0 : r_y - w_mv_step;
        DIR_D: w_y_nxt = (w_y_inc > (POS_W+1)'(Y_MAX)) ? POS_W'(Y_MAX) : w_y_inc[POS_W-1:0];
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    moving   = (r_state == MOVE);
    bouncing = (r_state == BOUNCE);
  end

  assign xpos      = r_x;
  assign ypos      = r_y;
  assign facing    = r_face;
  assign dx        = DrawX - r_x;
  assign dy        = DrawY - r_y;
  assign in_sprite = (dx < POS_W'(SPR_W)) && (dy < POS_W'(SPR_H));
  assign at_start  = enable && (r_y < POS_W'(START_LINE));
  assign at_end    = enable && (r_y > POS_W'(END_LINE));

endmodule

// File: tb/tb_sprite_mover.sv
// Directed self-checking bench for sprite_mover (default parameters).
module tb_sprite_mover;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, restart, enable, boost;
  logic [7:0] keycode;
  logic [3:0] blocked;
  logic [9:0] DrawX, DrawY;
  logic [9:0] xpos, ypos, dx, dy;
  logic [1:0] facing;
  logic       moving, bouncing, in_sprite, at_start, at_end;

  int checks = 0;
  int errors = 0;

  sprite_mover dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .restart(restart),
    .enable(enable), .keycode(keycode), .blocked(blocked), .boost(boost),
    .DrawX(DrawX), .DrawY(DrawY), .xpos(xpos), .ypos(ypos), .dx(dx), .dy(dy),
    .facing(facing), .moving(moving), .bouncing(bouncing),
    .in_sprite(in_sprite), .at_start(at_start), .at_end(at_end)
  );

  always #5 Clk = ~Clk;

  // One frame strobe; returns #1 after the edge that applies the tick.
  task automatic do_tick;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; restart = 1'b0; enable = 1'b1;
    keycode = 8'h00; blocked = 4'h0; boost = 1'b0; DrawX = '0; DrawY = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (xpos !== 10'd336) begin errors++; $display("FAIL reset_xpos got %0d exp 336", xpos); end
    checks++; if (ypos !== 10'd33) begin errors++; $display("FAIL reset_ypos got %0d exp 33", ypos); end
    checks++; if (facing !== 2'd3) begin errors++; $display("FAIL reset_facing got %0d exp 3", facing); end
    checks++; if ({moving, bouncing} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {moving, bouncing}); end
    checks++; if ({at_start, at_end} !== 2'b10) begin errors++; $display("FAIL reset_zone got %b exp 10", {at_start, at_end}); end
  endtask

  task automatic test_move_right;
    do_reset();
    keycode = 8'h07;
    // latency: nothing after the first edge, update on the second
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk); #1;
    checks++; if (xpos !== 10'd336) begin errors++; $display("FAIL latency_early got %0d exp 336", xpos); end
    @(negedge Clk) frame_clk = 1'b0;
    @(posedge Clk); #1;
    checks++; if (xpos !== 10'd337) begin errors++; $display("FAIL latency_update got %0d exp 337", xpos); end
    do_tick(); do_tick();
    checks++; if (xpos !== 10'd339) begin errors++; $display("FAIL right_xpos got %0d exp 339", xpos); end
    checks++; if (ypos !== 10'd33) begin errors++; $display("FAIL right_ypos got %0d exp 33", ypos); end
    checks++; if (facing !== 2'd1) begin errors++; $display("FAIL right_facing got %0d exp 1", facing); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL right_moving got %b exp 1", moving); end
  endtask

  // Continues from test_move_right (MOVE, xpos 339, facing R).
  task automatic test_bounce;
    blocked = 4'b0010;
    do_tick();
    checks++; if (bouncing !== 1'b1) begin errors++; $display("FAIL bounce_entry got %b exp 1", bouncing); end
    checks++; if (xpos !== 10'd338) begin errors++; $display("FAIL bounce_entry_x got %0d exp 338", xpos); end
    keycode = 8'h1A; blocked = 4'h0;
    do_tick();
    checks++; if (xpos !== 10'd337) begin errors++; $display("FAIL bounce_t1 got %0d exp 337", xpos); end
    // enable low freezes the bounce and forces zone flags low
    enable = 1'b0;
    do_tick();
    checks++; if (xpos !== 10'd337 || bouncing !== 1'b1) begin errors++; $display("FAIL bounce_freeze got x=%0d b=%b exp x=337 b=1", xpos, bouncing); end
    checks++; if (at_start !== 1'b0) begin errors++; $display("FAIL enable_zone got %b exp 0", at_start); end
    enable = 1'b1;
    keycode = 8'h04;
    do_tick();
    checks++; if (xpos !== 10'd336) begin errors++; $display("FAIL bounce_t2 got %0d exp 336", xpos); end
    do_tick();
    checks++; if (xpos !== 10'd335 || bouncing !== 1'b1) begin errors++; $display("FAIL bounce_t3 got x=%0d b=%b exp x=335 b=1", xpos, bouncing); end
    do_tick();
    checks++; if (xpos !== 10'd334) begin errors++; $display("FAIL bounce_t4 got %0d exp 334", xpos); end
    checks++; if ({moving, bouncing} !== 2'b00) begin errors++; $display("FAIL bounce_exit got %b exp 00", {moving, bouncing}); end
    checks++; if (ypos !== 10'd33 || facing !== 2'd1) begin errors++; $display("FAIL bounce_keep got y=%0d f=%0d exp y=33 f=1", ypos, facing); end
  endtask

  task automatic test_idle_blocked;
    do_reset();
    keycode = 8'h1A; blocked = 4'b0100;
    do_tick();
    checks++; if (facing !== 2'd2) begin errors++; $display("FAIL idle_blk_facing got %0d exp 2", facing); end
    checks++; if (ypos !== 10'd33 || moving !== 1'b0) begin errors++; $display("FAIL idle_blk_hold got y=%0d m=%b exp y=33 m=0", ypos, moving); end
  endtask

  task automatic test_left_clamp;
    do_reset();
    keycode = 8'h04;
    repeat (335) do_tick();
    checks++; if (xpos !== 10'd1) begin errors++; $display("FAIL left_reach got %0d exp 1", xpos); end
    for (int i = 0; i < 3; i++) begin
      do_tick();
      checks++; if (xpos !== 10'd0) begin errors++; $display("FAIL left_clamp%0d got %0d exp 0", i, xpos); end
    end
  endtask

  task automatic test_end_restart;
    do_reset();
    keycode = 8'h16;
    repeat (382) do_tick();
    checks++; if (ypos !== 10'd415) begin errors++; $display("FAIL down_reach got %0d exp 415", ypos); end
    do_tick();
    checks++; if (ypos !== 10'd416 || at_end !== 1'b0) begin errors++; $display("FAIL end_edge got y=%0d e=%b exp y=416 e=0", ypos, at_end); end
    do_tick();
    checks++; if (ypos !== 10'd417 || at_end !== 1'b1) begin errors++; $display("FAIL end_zone got y=%0d e=%b exp y=417 e=1", ypos, at_end); end
    keycode = 8'h00;
    @(negedge Clk) restart = 1'b1;
    @(negedge Clk) restart = 1'b0;
    #1;
    checks++; if (xpos !== 10'd336 || ypos !== 10'd33) begin errors++; $display("FAIL restart_pos got %0d,%0d exp 336,33", xpos, ypos); end
    checks++; if ({at_start, at_end} !== 2'b10) begin errors++; $display("FAIL restart_zone got %b exp 10", {at_start, at_end}); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL restart_moving got %b exp 0", moving); end
  endtask

  task automatic test_in_sprite;
    do_reset();
    DrawX = 10'd355; DrawY = 10'd33; #1;
    checks++; if (in_sprite !== 1'b1 || dx !== 10'd19) begin errors++; $display("FAIL hit_edge got i=%b dx=%0d exp i=1 dx=19", in_sprite, dx); end
    DrawX = 10'd356; #1;
    checks++; if (in_sprite !== 1'b0) begin errors++; $display("FAIL hit_right got %b exp 0", in_sprite); end
    DrawX = 10'd335; #1;
    checks++; if (in_sprite !== 1'b0 || dx !== 10'd1023) begin errors++; $display("FAIL hit_left got i=%b dx=%0d exp i=0 dx=1023", in_sprite, dx); end
    DrawX = 10'd340; DrawY = 10'd52; #1;
    checks++; if (in_sprite !== 1'b1) begin errors++; $display("FAIL hit_bottom got %b exp 1", in_sprite); end
    DrawY = 10'd53; #1;
    checks++; if (in_sprite !== 1'b0 || dy !== 10'd20) begin errors++; $display("FAIL hit_below got i=%b dy=%0d exp i=0 dy=20", in_sprite, dy); end
  endtask

  task automatic test_boost;
    logic [9:0] exp_x;
`ifdef SPRITE_BOOST_EN
    exp_x = 10'd340;
`else
    exp_x = 10'd338;
`endif
    do_reset();
    boost = 1'b1; keycode = 8'h07;
    do_tick(); do_tick();
    checks++; if (xpos !== exp_x) begin errors++; $display("FAIL boost_x got %0d exp %0d", xpos, exp_x); end
    boost = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; restart = 1'b0; enable = 1'b1;
    keycode = 8'h00; blocked = 4'h0; boost = 1'b0; DrawX = '0; DrawY = '0;
    test_reset();
    test_move_right();
    test_bounce();
    test_idle_blocked();
    test_left_clamp();
    test_end_restart();
    test_in_sprite();
    test_boost();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
